// File: rtl/suma_resta_display.sv
// Captures an adder/subtractor result, converts it to sign/tens/units by
// repeated subtraction of 10, and scans it onto a 3-digit active-low display.
module suma_resta_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       op,
  input  logic [4:0] s,
  input  logic       load,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       busy,
  output logic       done
);

  localparam int              CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [6:0]      SEG_BLANK = 7'b1111111;
  localparam logic [6:0]      SEG_MINUS = 7'b0111111;

  typedef enum logic {IDLE, CONV} state_t;

  state_t        state_reg, state_next;
  logic          neg_reg, neg_next;
  logic [4:0]    mag_reg, mag_next;
  logic [1:0]    tens_acc_reg, tens_acc_next;
  logic          disp_sign_reg, disp_sign_next;
  logic [1:0]    disp_tens_reg, disp_tens_next;
  logic [3:0]    disp_units_reg, disp_units_next;
  logic          done_reg, done_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    scan_reg, scan_next;
  logic [6:0]    seg_reg, seg_next;

  function automatic logic [6:0] digit_code(input logic [3:0] d);
    logic [6:0] code;
    case (d)
      4'd0:    code = 7'b1000000;
      4'd1:    code = 7'b1111001;
      4'd2:    code = 7'b0100100;
      4'd3:    code = 7'b0110000;
      4'd4:    code = 7'b0011001;
      4'd5:    code = 7'b0010010;
      4'd6:    code = 7'b0000010;
      4'd7:    code = 7'b1111000;
      4'd8:    code = 7'b0000000;
      4'd9:    code = 7'b0010000;
      default: code = SEG_BLANK;
    endcase
    return code;
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      neg_reg        <= 1'b0;
      mag_reg        <= '0;
      tens_acc_reg   <= '0;
      disp_sign_reg  <= 1'b0;
      disp_tens_reg  <= '0;
      disp_units_reg <= '0;
      done_reg       <= 1'b0;
      cnt_reg        <= '0;
      scan_reg       <= '0;
      seg_reg        <= 7'b1000000;
    end else begin
      state_reg      <= state_next;
      neg_reg        <= neg_next;
      mag_reg        <= mag_next;
      tens_acc_reg   <= tens_acc_next;
      disp_sign_reg  <= disp_sign_next;
      disp_tens_reg  <= disp_tens_next;
      disp_units_reg <= disp_units_next;
      done_reg       <= done_next;
      cnt_reg        <= cnt_next;
      scan_reg       <= scan_next;
      seg_reg        <= seg_next;
    end
  end

  // Conversion FSM
  always_comb begin
    state_next      = state_reg;
    neg_next        = neg_reg;
    mag_next        = mag_reg;
    tens_acc_next   = tens_acc_reg;
    disp_sign_next  = disp_sign_reg;
    disp_tens_next  = disp_tens_reg;
    disp_units_next = disp_units_reg;
    done_next       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (load) begin
          neg_next      = op & s[4];
          // Two's-complement negate; 5'b10000 maps to 16 naturally.
          mag_next      = (op & s[4]) ? (~s + 5'd1) : s;
          tens_acc_next = '0;
          state_next    = CONV;
        end
      end
      CONV: begin
        if (mag_reg >= 5'd10) begin
          mag_next      = mag_reg - 5'd10;
          tens_acc_next = tens_acc_reg + 2'd1;
        end else begin
          disp_sign_next  = neg_reg;
          disp_tens_next  = tens_acc_reg;
          disp_units_next = mag_reg[3:0];
          done_next       = 1'b1;
          state_next      = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Free-running digit scan
  always_comb begin
    cnt_next  = cnt_reg + 1'b1;
    scan_next = scan_reg;
    if (cnt_reg == CNT_MAX) begin
      cnt_next  = '0;
      scan_next = (scan_reg == 2'd2) ? 2'd0 : scan_reg + 2'd1;
    end
  end

  // Segment register is loaded from next-cycle index and digits so seg stays aligned with an.
  always_comb begin
    case (scan_next)
      2'd0:    seg_next = digit_code(disp_units_next);
      2'd1:    seg_next = (disp_tens_next == 2'd0) ? SEG_BLANK : digit_code({2'b00, disp_tens_next});
      2'd2:    seg_next = disp_sign_next ? SEG_MINUS : SEG_BLANK;
      default: seg_next = SEG_BLANK;
    endcase
  end

  always_comb begin
    case (scan_reg)
      2'd0:    an = 3'b110;
      2'd1:    an = 3'b101;
      2'd2:    an = 3'b011;
      default: an = 3'b111;
    endcase
  end

  assign seg  = seg_reg;
  assign busy = (state_reg == CONV);
  assign done = done_reg;

endmodule

// File: tb/tb_suma_resta_display.sv
// Directed plus randomized checks of suma_resta_display against an arithmetic
// model of value conversion and digit scanning.
module tb_suma_resta_display;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       op = 1'b0;
  logic [4:0] s = '0;
  logic       load = 1'b0;
  logic [6:0] seg;
  logic [2:0] an;
  logic       busy;
  logic       done;

  int vectors = 0;
  int miscompares = 0;
  int edges = 0;

  // Model of what is on the display
  bit m_neg = 0;
  int m_tens = 0;
  int m_units = 0;

  logic [6:0] digit_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  suma_resta_display #(.REFRESH_DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .s(s), .load(load),
    .seg(seg), .an(an), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  function automatic int scan_idx();
    return (edges / DIV) % 3;
  endfunction

  function automatic logic [2:0] exp_an();
    case (scan_idx())
      0:       return 3'b110;
      1:       return 3'b101;
      default: return 3'b011;
    endcase
  endfunction

  function automatic logic [6:0] exp_seg();
    case (scan_idx())
      0:       return digit_tab[m_units];
      1:       return (m_tens == 0) ? 7'b1111111 : digit_tab[m_tens];
      default: return m_neg ? 7'b0111111 : 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("an", 32'(an), 32'(exp_an()));
    chk("seg", 32'(seg), 32'(exp_seg()));
  endtask

  task automatic run_load(input bit op_v, input logic [4:0] s_v);
    bit ng;
    int mag, k;
    ng  = op_v && s_v[4];
    mag = ng ? 32 - int'(s_v) : int'(s_v);
    k   = mag / 10;
    op = op_v; s = s_v; load = 1'b1;
    tick();
    load = 1'b0; s = 5'($urandom); op = 1'($urandom);
    chk("busy_e0", 32'(busy), 32'd1);
    chk("done_e0", 32'(done), 32'd0);
    for (int j = 1; j <= k; j++) begin
      tick();
      chk("busy_conv", 32'(busy), 32'd1);
      chk("done_conv", 32'(done), 32'd0);
    end
    m_neg = ng; m_tens = k; m_units = mag % 10;
    tick();
    chk("busy_commit", 32'(busy), 32'd0);
    chk("done_commit", 32'(done), 32'd1);
    $display("load op=%0d s=%b -> %s%0d after %0d cycles", op_v, s_v, ng ? "-" : "+", mag, k + 1);
  endtask

  task automatic scan_all();
    for (int j = 0; j < 3 * DIV; j++) begin
      tick();
      chk("done_idle", 32'(done), 32'd0);
    end
  endtask

  initial begin
    int pulses;
    // Asynchronous reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("rst_an", 32'(an), 32'(3'b110));
    chk("rst_seg", 32'(seg), 32'(7'b1000000));
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    scan_all();

    run_load(1'b0, 5'd30);
    scan_all();
    run_load(1'b1, 5'b11001);
    scan_all();
    run_load(1'b1, 5'b10000);
    scan_all();
    // Back-to-back: load accepted on the edge right after commit
    run_load(1'b0, 5'd9);
    run_load(1'b0, 5'd31);
    scan_all();

    // Load held / re-asserted while busy is dropped
    pulses = 0;
    op = 1'b0; s = 5'd25; load = 1'b1;
    tick();
    chk("drop_busy_e0", 32'(busy), 32'd1);
    s = 5'd3;
    tick();
    chk("drop_done_e1", 32'(done), 32'd0);
    tick();
    chk("drop_done_e2", 32'(done), 32'd0);
    load = 1'b0;
    m_neg = 0; m_tens = 2; m_units = 5;
    tick();
    if (done === 1'b1) pulses++;
    chk("drop_busy_commit", 32'(busy), 32'd0);
    for (int j = 0; j < 3 * DIV; j++) begin
      tick();
      if (done === 1'b1) pulses++;
      chk("drop_busy_after", 32'(busy), 32'd0);
    end
    chk("drop_pulses", 32'(pulses), 32'd1);
    $display("busy drop: done pulses=%0d", pulses);

    // Reset in the middle of a conversion
    op = 1'b0; s = 5'd30; load = 1'b1;
    tick();
    load = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    m_neg = 0; m_tens = 0; m_units = 0;
    chk("midrst_an", 32'(an), 32'(3'b110));
    chk("midrst_seg", 32'(seg), 32'(7'b1000000));
    chk("midrst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int j = 0; j < 10; j++) begin
      tick();
      chk("midrst_done", 32'(done), 32'd0);
      chk("midrst_busy_after", 32'(busy), 32'd0);
    end
    $display("reset mid-conversion: display +0");

    // Randomized loads, some back-to-back, some with a full scan between
    for (int n = 0; n < 30; n++) begin
      run_load(1'($urandom), 5'($urandom));
      if ($urandom_range(1, 0) == 1) scan_all();
    end
    scan_all();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
